// File: rtl/ctrl_pipe.sv
// RV32IM control unit: decodes the ID instruction into the ID/EX control word (one-cycle latency).
// stall is combinational and holds PC and IF/ID on a load-use hazard and while a MUL/DIV occupies EX.
module ctrl_pipe #(
    parameter bit MULDIV_EN   = 1'b1,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic        ex_flush,
    output logic        stall,
    output logic        md_busy,
    output logic        illegal,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memwrite,
    output logic        ex_memread,
    output logic        ex_alusrc,
    output logic        ex_md,
    output logic [4:0]  ex_aluop,
    output logic [2:0]  ex_npcop,
    output logic [1:0]  ex_wdsel,
    output logic [1:0]  ex_gprsel,
    output logic [2:0]  ex_dmtype,
    output logic [5:0]  ex_extop,
    output logic [2:0]  ex_mdop,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MD   = 7'b0000001;

    localparam logic [4:0] ALU_LUI   = 5'b00001;
    localparam logic [4:0] ALU_AUIPC = 5'b00010;
    localparam logic [4:0] ALU_ADD   = 5'b00011;
    localparam logic [4:0] ALU_SUB   = 5'b00100;
    localparam logic [4:0] ALU_BNE   = 5'b00101;
    localparam logic [4:0] ALU_BLT   = 5'b00110;
    localparam logic [4:0] ALU_BGE   = 5'b00111;
    localparam logic [4:0] ALU_BLTU  = 5'b01000;
    localparam logic [4:0] ALU_BGEU  = 5'b01001;
    localparam logic [4:0] ALU_SLT   = 5'b01010;
    localparam logic [4:0] ALU_SLTU  = 5'b01011;
    localparam logic [4:0] ALU_XOR   = 5'b01100;
    localparam logic [4:0] ALU_OR    = 5'b01101;
    localparam logic [4:0] ALU_AND   = 5'b01110;
    localparam logic [4:0] ALU_SLL   = 5'b01111;
    localparam logic [4:0] ALU_SRL   = 5'b10000;
    localparam logic [4:0] ALU_SRA   = 5'b10001;

    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;
    localparam logic [1:0] GPR_31 = 2'b10;

    localparam logic [2:0] DM_WORD  = 3'b000;
    localparam logic [2:0] DM_HALF  = 3'b001;
    localparam logic [2:0] DM_HALFU = 3'b010;
    localparam logic [2:0] DM_BYTE  = 3'b011;
    localparam logic [2:0] DM_BYTEU = 3'b100;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LATENCY - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LATENCY - 1);

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic       memread;
        logic       alusrc;
        logic       md;
        logic [4:0] aluop;
        logic [2:0] npcop;
        logic [1:0] wdsel;
        logic [1:0] gprsel;
        logic [2:0] dmtype;
        logic [5:0] extop;
        logic [2:0] mdop;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_t;

    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign op  = id_inst[6:0];
    assign rd  = id_inst[11:7];
    assign f3  = id_inst[14:12];
    assign rs1 = id_inst[19:15];
    assign rs2 = id_inst[24:20];
    assign f7  = id_inst[31:25];

    ctrl_t      dec;
    ctrl_t      ex_q;
    logic       legal;
    logic       load_use;
    logic       md_hold;
    logic [3:0] md_cnt;

    // Register indices an instruction does not use are left at zero in the word.
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.aluop = ALU_ADD;
        legal     = 1'b1;
        case (op)
            OP_R: begin
                dec.regwrite = 1'b1;
                dec.rd       = rd;
                dec.rs1      = rs1;
                dec.rs2      = rs2;
                if (f7 == F7_MD) begin
                    if (MULDIV_EN) begin
                        dec.md   = 1'b1;
                        dec.mdop = f3;
                    end else begin
                        legal = 1'b0;
                    end
                end else if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  dec.aluop = ALU_ADD;
                        3'b001:  dec.aluop = ALU_SLL;
                        3'b010:  dec.aluop = ALU_SLT;
                        3'b011:  dec.aluop = ALU_SLTU;
                        3'b100:  dec.aluop = ALU_XOR;
                        3'b101:  dec.aluop = ALU_SRL;
                        3'b110:  dec.aluop = ALU_OR;
                        default: dec.aluop = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    dec.aluop = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    dec.aluop = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_I: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.rd       = rd;
                dec.rs1      = rs1;
                dec.extop    = 6'b010000;
                case (f3)
                    3'b000: dec.aluop = ALU_ADD;
                    3'b010: dec.aluop = ALU_SLT;
                    3'b011: dec.aluop = ALU_SLTU;
                    3'b100: dec.aluop = ALU_XOR;
                    3'b110: dec.aluop = ALU_OR;
                    3'b111: dec.aluop = ALU_AND;
                    3'b001: begin
                        dec.extop = 6'b100000;
                        dec.aluop = ALU_SLL;
                        legal     = (f7 == F7_BASE);
                    end
                    default: begin
                        dec.extop = 6'b100000;
                        dec.aluop = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        legal     = (f7 == F7_BASE) || (f7 == F7_ALT);
                    end
                endcase
            end
            OP_LOAD: begin
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                dec.alusrc   = 1'b1;
                dec.wdsel    = WD_MEM;
                dec.extop    = 6'b010000;
                dec.rd       = rd;
                dec.rs1      = rs1;
                case (f3)
                    3'b000:  dec.dmtype = DM_BYTE;
                    3'b001:  dec.dmtype = DM_HALF;
                    3'b100:  dec.dmtype = DM_BYTEU;
                    3'b101:  dec.dmtype = DM_HALFU;
                    default: dec.dmtype = DM_WORD;
                endcase
            end
            OP_STORE: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.extop    = 6'b001000;
                dec.rs1      = rs1;
                dec.rs2      = rs2;
                case (f3)
                    3'b000:  dec.dmtype = DM_BYTE;
                    3'b001:  dec.dmtype = DM_HALF;
                    default: dec.dmtype = DM_WORD;
                endcase
            end
            OP_BR: begin
                dec.npcop = NPC_BRANCH;
                dec.extop = 6'b000100;
                dec.rs1   = rs1;
                dec.rs2   = rs2;
                case (f3)
                    3'b000:  dec.aluop = ALU_SUB;
                    3'b001:  dec.aluop = ALU_BNE;
                    3'b100:  dec.aluop = ALU_BLT;
                    3'b101:  dec.aluop = ALU_BGE;
                    3'b110:  dec.aluop = ALU_BLTU;
                    3'b111:  dec.aluop = ALU_BGEU;
                    default: dec.aluop = ALU_ADD;
                endcase
            end
            OP_LUI, OP_AUIPC: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.extop    = 6'b000010;
                dec.rd       = rd;
                dec.aluop    = (op == OP_LUI) ? ALU_LUI : ALU_AUIPC;
            end
            OP_JAL: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.npcop    = NPC_JUMP;
                dec.wdsel    = WD_PC;
                dec.gprsel   = GPR_31;
                dec.extop    = 6'b000001;
                dec.rd       = rd;
            end
            OP_JALR: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.npcop    = NPC_JALR;
                dec.wdsel    = WD_PC;
                dec.extop    = 6'b010000;
                dec.rd       = rd;
                dec.rs1      = rs1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Unused sources are zero in dec and ex_rd is non-zero here, so they never match.
    assign load_use = ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) & id_valid & legal &
                      ((dec.rs1 == ex_q.rd) | (dec.rs2 == ex_q.rd));
    assign md_hold  = (md_cnt != 4'd0);
    assign md_busy  = md_hold;
    assign stall    = md_hold | (load_use & ~ex_flush);
    assign illegal  = id_valid & ~legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q   <= '0;
            md_cnt <= 4'd0;
        end else if (md_hold) begin
            md_cnt <= md_cnt - 4'd1;
        end else if (ex_flush | load_use | ~id_valid | ~legal) begin
            ex_q <= '0;
        end else begin
            ex_q <= dec;
            if (dec.md) begin
                md_cnt <= f3[2] ? DIV_CNT : MUL_CNT;
            end
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_md       = ex_q.md;
    assign ex_aluop    = ex_q.aluop;
    assign ex_npcop    = ex_q.npcop;
    assign ex_wdsel    = ex_q.wdsel;
    assign ex_gprsel   = ex_q.gprsel;
    assign ex_dmtype   = ex_q.dmtype;
    assign ex_extop    = ex_q.extop;
    assign ex_mdop     = ex_q.mdop;
    assign ex_rd       = ex_q.rd;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a vector table for decode and hazards, plus sequences for MUL/DIV and reset.
module tb_ctrl_pipe;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic       memread;
        logic       alusrc;
        logic       md;
        logic [4:0] aluop;
        logic [2:0] npcop;
        logic [1:0] wdsel;
        logic [1:0] gprsel;
        logic [2:0] dmtype;
        logic [5:0] extop;
        logic [2:0] mdop;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } word_t;

    typedef struct {
        logic        vld;
        logic [31:0] inst;
        logic        flush;
        logic        exp_stall;
        logic        exp_ill;
        word_t       exp;
    } vec_t;

    localparam logic [4:0] ADD = 5'b00011;
    localparam logic [4:0] SUB = 5'b00100;
    localparam logic [4:0] LUI = 5'b00001;
    localparam logic [4:0] SRA = 5'b10001;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_inst;
    logic        ex_flush;

    logic  stall, md_busy, illegal;
    logic  stall_b, md_busy_b, illegal_b;
    logic  stall_c, md_busy_c, illegal_c;
    wire word_t act;
    wire word_t act_b;
    wire word_t act_c;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    ctrl_pipe #(.MULDIV_EN(1'b1), .MUL_LATENCY(2), .DIV_LATENCY(8)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .ex_flush(ex_flush),
        .stall(stall), .md_busy(md_busy), .illegal(illegal),
        .ex_valid(act.valid), .ex_regwrite(act.regwrite), .ex_memwrite(act.memwrite),
        .ex_memread(act.memread), .ex_alusrc(act.alusrc), .ex_md(act.md),
        .ex_aluop(act.aluop), .ex_npcop(act.npcop), .ex_wdsel(act.wdsel), .ex_gprsel(act.gprsel),
        .ex_dmtype(act.dmtype), .ex_extop(act.extop), .ex_mdop(act.mdop),
        .ex_rd(act.rd), .ex_rs1(act.rs1), .ex_rs2(act.rs2)
    );

    ctrl_pipe #(.MULDIV_EN(1'b1), .MUL_LATENCY(1), .DIV_LATENCY(8)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .ex_flush(ex_flush),
        .stall(stall_b), .md_busy(md_busy_b), .illegal(illegal_b),
        .ex_valid(act_b.valid), .ex_regwrite(act_b.regwrite), .ex_memwrite(act_b.memwrite),
        .ex_memread(act_b.memread), .ex_alusrc(act_b.alusrc), .ex_md(act_b.md),
        .ex_aluop(act_b.aluop), .ex_npcop(act_b.npcop), .ex_wdsel(act_b.wdsel), .ex_gprsel(act_b.gprsel),
        .ex_dmtype(act_b.dmtype), .ex_extop(act_b.extop), .ex_mdop(act_b.mdop),
        .ex_rd(act_b.rd), .ex_rs1(act_b.rs1), .ex_rs2(act_b.rs2)
    );

    ctrl_pipe #(.MULDIV_EN(1'b0), .MUL_LATENCY(2), .DIV_LATENCY(8)) dut_c (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .ex_flush(ex_flush),
        .stall(stall_c), .md_busy(md_busy_c), .illegal(illegal_c),
        .ex_valid(act_c.valid), .ex_regwrite(act_c.regwrite), .ex_memwrite(act_c.memwrite),
        .ex_memread(act_c.memread), .ex_alusrc(act_c.alusrc), .ex_md(act_c.md),
        .ex_aluop(act_c.aluop), .ex_npcop(act_c.npcop), .ex_wdsel(act_c.wdsel), .ex_gprsel(act_c.gprsel),
        .ex_dmtype(act_c.dmtype), .ex_extop(act_c.extop), .ex_mdop(act_c.mdop),
        .ex_rd(act_c.rd), .ex_rs1(act_c.rs1), .ex_rs2(act_c.rs2)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    function automatic word_t w(input logic v, rw, mw, mr, as, md, input logic [4:0] alu,
                                input logic [2:0] npc, input logic [1:0] wd, gpr,
                                input logic [2:0] dm, input logic [5:0] ext, input logic [2:0] mdop,
                                input logic [4:0] rd, rs1, rs2);
        return {v, rw, mw, mr, as, md, alu, npc, wd, gpr, dm, ext, mdop, rd, rs1, rs2};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    task automatic add_vec(input logic vld, input logic [31:0] inst, input logic flush,
                           input logic es, input logic ei, input word_t exp);
        vec_t v;
        v.vld = vld; v.inst = inst; v.flush = flush;
        v.exp_stall = es; v.exp_ill = ei; v.exp = exp;
        vq.push_back(v);
    endtask

    // Counts stall cycles of the main DUT from the current negedge; bounded to 20 cycles.
    task automatic count_hold(output int n, output int nbusy, output int nb);
        n = 0; nbusy = 0; nb = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (stall_b) nb++;
            if (md_busy) nbusy++;
            if (!stall) break;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        word_t bub;
        logic [31:0] add3, lw5, add65, mul7, div7;
        int n, nbusy, nb;
        bub   = '0;
        add3  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
        lw5   = enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011);
        add65 = enc_r(7'b0000000, 5'd2, 5'd5, 3'b000, 5'd6);
        mul7  = enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd7);
        div7  = enc_r(7'b0000001, 5'd2, 5'd1, 3'b100, 5'd7);

        add_vec(1, add3, 0, 0, 0, w(1,1,0,0,0,0,ADD,0,0,0,0,6'b0,0,3,1,2));
        add_vec(1, lw5, 0, 0, 0, w(1,1,0,1,1,0,ADD,0,2'b01,0,3'b000,6'b010000,0,5,1,0));
        add_vec(1, add65, 0, 1, 0, bub);
        add_vec(1, add65, 0, 0, 0, w(1,1,0,0,0,0,ADD,0,0,0,0,6'b0,0,6,5,2));
        add_vec(1, enc_i(12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011), 0, 0, 0,
                w(1,1,0,1,1,0,ADD,0,2'b01,0,3'b000,6'b010000,0,0,1,0));
        add_vec(1, enc_r(7'b0, 5'd2, 5'd0, 3'b000, 5'd6), 0, 0, 0, w(1,1,0,0,0,0,ADD,0,0,0,0,6'b0,0,6,0,2));
        add_vec(1, lw5, 0, 0, 0, w(1,1,0,1,1,0,ADD,0,2'b01,0,3'b000,6'b010000,0,5,1,0));
        add_vec(1, add65, 1, 0, 0, bub);
        add_vec(1, enc_s(12'd4, 5'd2, 5'd1), 0, 0, 0, w(1,0,1,0,1,0,ADD,0,0,0,3'b000,6'b001000,0,0,1,2));
        add_vec(1, {7'b0, 5'd2, 5'd1, 3'b000, 5'b01000, 7'b1100011}, 0, 0, 0,
                w(1,0,0,0,0,0,SUB,3'b001,0,0,0,6'b000100,0,0,1,2));
        add_vec(1, {20'h00800, 5'd1, 7'b1101111}, 0, 0, 0, w(1,1,0,0,1,0,ADD,3'b010,2'b10,2'b10,0,6'b000001,0,1,0,0));
        add_vec(1, {20'h12345, 5'd9, 7'b0110111}, 0, 0, 0, w(1,1,0,0,1,0,LUI,0,0,0,0,6'b000010,0,9,0,0));
        add_vec(1, {7'b0100000, 5'd3, 5'd4, 3'b101, 5'd10, 7'b0010011}, 0, 0, 0,
                w(1,1,0,0,1,0,SRA,0,0,0,0,6'b100000,0,10,4,0));
        add_vec(1, enc_i(12'd0, 5'd5, 3'b000, 5'd1, 7'b1100111), 0, 0, 0,
                w(1,1,0,0,1,0,ADD,3'b100,2'b10,0,0,6'b010000,0,1,5,0));
        add_vec(1, 32'h0000007F, 0, 0, 1, bub);
        add_vec(0, 32'hFFFFFFFF, 0, 0, 0, bub);
        add_vec(1, enc_i(12'd2, 5'd3, 3'b001, 5'd11, 7'b0000011), 0, 0, 0,
                w(1,1,0,1,1,0,ADD,0,2'b01,0,3'b001,6'b010000,0,11,3,0));
        add_vec(1, enc_i(12'd0, 5'd3, 3'b100, 5'd12, 7'b0000011), 0, 0, 0,
                w(1,1,0,1,1,0,ADD,0,2'b01,0,3'b100,6'b010000,0,12,3,0));
        add_vec(1, enc_i(12'd0, 5'd1, 3'b010, 5'd13, 7'b0000011), 0, 0, 0,
                w(1,1,0,1,1,0,ADD,0,2'b01,0,3'b000,6'b010000,0,13,1,0));
        add_vec(1, enc_s(12'd0, 5'd13, 5'd2), 0, 1, 0, bub);
        add_vec(1, enc_s(12'd0, 5'd13, 5'd2), 0, 0, 0, w(1,0,1,0,1,0,ADD,0,0,0,3'b000,6'b001000,0,0,2,13));
        add_vec(1, {7'b0100000, 5'd1, 5'd2, 3'b001, 5'd1, 7'b0010011}, 0, 0, 1, bub);

        // Reset held with a valid add in ID.
        rst = 1'b1; id_valid = 1'b1; id_inst = add3; ex_flush = 1'b0;
        #1;
        chk("rst_word", 64'(act), 64'(bub));
        chk("rst_busy", 64'(md_busy), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_illegal", 64'(illegal), 64'(0));
        @(posedge clk); #1;
        chk("rst_word_edge", 64'(act), 64'(bub));
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            id_valid = vq[i].vld; id_inst = vq[i].inst; ex_flush = vq[i].flush;
            #1;
            chk($sformatf("vec%0d_stall", i), 64'(stall), 64'(vq[i].exp_stall));
            chk($sformatf("vec%0d_illegal", i), 64'(illegal), 64'(vq[i].exp_ill));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_word", i), 64'(act), 64'(vq[i].exp));
            chk($sformatf("vec%0d_busy", i), 64'(md_busy), 64'(0));
            @(negedge clk);
        end
        ex_flush = 1'b0;

        // mul: two cycles in EX here, one with MUL_LATENCY=1, illegal without M-ext.
        id_valid = 1'b1; id_inst = mul7;
        #1;
        chk("mul_pre_stall", 64'(stall), 64'(0));
        chk("mul_illegal_noext", 64'(illegal_c), 64'(1));
        chk("mul_illegal_ext", 64'(illegal), 64'(0));
        @(posedge clk); #1;
        chk("mul_word", 64'(act), 64'(w(1,1,0,0,0,1,ADD,0,0,0,0,6'b0,3'b000,7,1,2)));
        chk("mul_busy", 64'(md_busy), 64'(1));
        chk("mul1_md", 64'(act_b.md), 64'(1));
        chk("mul1_busy", 64'(md_busy_b), 64'(0));
        chk("mul_noext_valid", 64'(act_c.valid), 64'(0));
        chk("mul_noext_regwrite", 64'(act_c.regwrite), 64'(0));
        @(negedge clk);
        id_inst = add3;
        count_hold(n, nbusy, nb);
        chk("mul_stall_cycles", 64'(n), 64'(1));
        chk("mul_busy_cycles", 64'(nbusy), 64'(1));
        chk("mul1_stall_cycles", 64'(nb), 64'(0));
        @(posedge clk); #1;
        chk("mul_next_word", 64'(act), 64'(w(1,1,0,0,0,0,ADD,0,0,0,0,6'b0,0,3,1,2)));
        @(negedge clk);

        // div: eight cycles in EX, seven of them stalled.
        id_inst = div7;
        #1;
        chk("div_pre_stall", 64'(stall), 64'(0));
        @(posedge clk); #1;
        chk("div_word", 64'(act), 64'(w(1,1,0,0,0,1,ADD,0,0,0,0,6'b0,3'b100,7,1,2)));
        @(negedge clk);
        id_inst = add3;
        count_hold(n, nbusy, nb);
        chk("div_stall_cycles", 64'(n), 64'(7));
        chk("div_busy_cycles", 64'(nbusy), 64'(7));
        chk("div_held_word", 64'(act), 64'(w(1,1,0,0,0,1,ADD,0,0,0,0,6'b0,3'b100,7,1,2)));
        @(posedge clk); #1;
        chk("div_next_word", 64'(act), 64'(w(1,1,0,0,0,0,ADD,0,0,0,0,6'b0,0,3,1,2)));
        @(negedge clk);

        // Reset pulse in the middle of a div.
        id_inst = div7;
        @(posedge clk);
        @(negedge clk);
        id_inst = add3;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); #1;
        chk("div_rst_pre_busy", 64'(md_busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("div_rst_busy", 64'(md_busy), 64'(0));
        chk("div_rst_valid", 64'(act.valid), 64'(0));
        chk("div_rst_stall", 64'(stall), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_stall", 64'(stall), 64'(0));
        @(posedge clk); #1;
        chk("post_rst_word", 64'(act), 64'(w(1,1,0,0,0,0,ADD,0,0,0,0,6'b0,0,3,1,2)));
        chk("post_rst_busy", 64'(md_busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
